// File: rtl/imsic_arb_pkg.sv
// imsic_arb_pkg
//   Shared types and constants for the IMSIC access arbiter slice:
//   - arb_state_e : arbiter FSM states (IDLE / BUSY / RESP)
//   - ImsicAddrW  : IMSIC register address width
//   - ImsicDataW  : IMSIC register data width
//   - hart_idx_w(): width of a hart index, never less than one bit
package imsic_arb_pkg;

    localparam int unsigned ImsicAddrW = 32;
    localparam int unsigned ImsicDataW = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    function automatic int unsigned hart_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/imsic_arb_rr.sv
// imsic_arb_rr
//   Combinational round-robin picker. Scans the request vector starting at
//   the pointer position and wrapping around; the first requester found wins.
//   Ports:
//     req_i   [NrHarts]  request vector
//     ptr_i   [HartW]    highest-priority hart index this round
//     grant_o [NrHarts]  one-hot winner, zero when nobody requests
module imsic_arb_rr
    import imsic_arb_pkg::*;
#(
    parameter int unsigned NrHarts = 2
) (
    input  logic [NrHarts-1:0]             req_i,
    input  logic [hart_idx_w(NrHarts)-1:0] ptr_i,
    output logic [NrHarts-1:0]             grant_o
);

    localparam int unsigned HartW = hart_idx_w(NrHarts);

    logic [HartW-1:0] idx;
    logic             found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NrHarts; i++) begin
            idx = HartW'((32'(ptr_i) + i) % NrHarts);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/imsic_access_arbiter.sv
// imsic_access_arbiter
//   Arbitrates NrHarts requesters onto a single IMSIC register port, one
//   access in flight at a time (IDLE -> BUSY -> RESP -> IDLE).
//   Optional feature macro: IMSIC_ARB_TIMEOUT_EN adds a BUSY watchdog that
//   forces a faulting response after TimeoutCycles cycles without completion.
//   Ports:
//     clk_i, rst_i                     clock, synchronous active-high reset
//     req_valid_i/req_ready_o          per-hart request / combinational grant
//     req_we_i/req_claim_i             per-hart write / read-and-claim flags
//     req_addr_i/req_wdata_i           per-hart address / write data
//     rsp_valid_o                      one-cycle response strobe to the winner
//     rsp_rdata_o/rsp_exception_o      shared response data / fault
//     imsic_valid_o, imsic_hart_o      IMSIC access strobe and hart index
//     imsic_addr_o/imsic_data_o        latched address / write data
//     imsic_we_o/imsic_claim_o         latched write / claim flags
//     imsic_rvalid_i                   IMSIC completion
//     imsic_data_i/imsic_exception_i   IMSIC read data / fault
module imsic_access_arbiter
    import imsic_arb_pkg::*;
#(
    parameter int unsigned NrHarts       = 2,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NrHarts-1:0]                 req_valid_i,
    output logic [NrHarts-1:0]                 req_ready_o,
    input  logic [NrHarts-1:0]                 req_we_i,
    input  logic [NrHarts-1:0]                 req_claim_i,
    input  logic [NrHarts-1:0][ImsicAddrW-1:0] req_addr_i,
    input  logic [NrHarts-1:0][ImsicDataW-1:0] req_wdata_i,
    output logic [NrHarts-1:0]                 rsp_valid_o,
    output logic [ImsicDataW-1:0]              rsp_rdata_o,
    output logic                               rsp_exception_o,
    output logic                               imsic_valid_o,
    output logic [hart_idx_w(NrHarts)-1:0]     imsic_hart_o,
    output logic [ImsicAddrW-1:0]              imsic_addr_o,
    output logic [ImsicDataW-1:0]              imsic_data_o,
    output logic                               imsic_we_o,
    output logic                               imsic_claim_o,
    input  logic                               imsic_rvalid_i,
    input  logic [ImsicDataW-1:0]              imsic_data_i,
    input  logic                               imsic_exception_i
);

    localparam int unsigned HartW = hart_idx_w(NrHarts);

    if (NrHarts < 2) begin : g_bad_nrharts
        $error("imsic_access_arbiter: NrHarts must be at least 2");
    end
    if (TimeoutCycles < 1 || TimeoutCycles > 65535) begin : g_bad_timeout
        $error("imsic_access_arbiter: TimeoutCycles must be 1..65535");
    end

    arb_state_e            state_q;
    logic [HartW-1:0]      ptr_q;
    logic [HartW-1:0]      idx_q;
    logic                  we_q;
    logic                  claim_q;
    logic [ImsicAddrW-1:0] addr_q;
    logic [ImsicDataW-1:0] wdata_q;
    logic [ImsicDataW-1:0] rdata_q;
    logic                  exc_q;

    logic [NrHarts-1:0]    win_oh;
    logic [HartW-1:0]      win_idx;

`ifdef IMSIC_ARB_TIMEOUT_EN
    localparam int unsigned TmoCntW = 16;
    logic [TmoCntW-1:0] tmo_cnt_q;
    logic [TmoCntW-1:0] tmo_cnt_d;
    assign tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif

    imsic_arb_rr #(
        .NrHarts(NrHarts)
    ) u_rr (
        .req_i  (req_valid_i),
        .ptr_i  (ptr_q),
        .grant_o(win_oh)
    );

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NrHarts; i++) begin
            if (win_oh[i]) win_idx = HartW'(i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            claim_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            exc_q   <= 1'b0;
`ifdef IMSIC_ARB_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (|req_valid_i) begin
                        state_q <= ST_BUSY;
                        idx_q   <= win_idx;
                        we_q    <= req_we_i[win_idx];
                        claim_q <= req_claim_i[win_idx];
                        addr_q  <= req_addr_i[win_idx];
                        wdata_q <= req_wdata_i[win_idx];
`ifdef IMSIC_ARB_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                    end
                end
                ST_BUSY: begin
                    if (imsic_rvalid_i) begin
                        state_q <= ST_RESP;
                        // plain writes never return data to the requester
                        rdata_q <= (we_q && !claim_q) ? '0 : imsic_data_i;
                        exc_q   <= imsic_exception_i;
                    end
`ifdef IMSIC_ARB_TIMEOUT_EN
                    else if (32'(tmo_cnt_d) >= TimeoutCycles) begin
                        state_q <= ST_RESP;
                        rdata_q <= '0;
                        exc_q   <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_d;
                    end
`endif
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    ptr_q   <= (idx_q == HartW'(NrHarts - 1)) ? '0 : idx_q + 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Grant is combinational from the IDLE state; suppressed while in reset.
    assign req_ready_o     = (state_q == ST_IDLE && !rst_i) ? win_oh : '0;

    assign imsic_valid_o   = (state_q == ST_BUSY);
    assign imsic_hart_o    = idx_q;
    assign imsic_addr_o    = addr_q;
    assign imsic_data_o    = wdata_q;
    assign imsic_we_o      = we_q;
    assign imsic_claim_o   = claim_q;

    always_comb begin
        rsp_valid_o = '0;
        if (state_q == ST_RESP) rsp_valid_o[idx_q] = 1'b1;
    end

    assign rsp_rdata_o     = (state_q == ST_RESP) ? rdata_q : '0;
    assign rsp_exception_o = (state_q == ST_RESP) && exc_q;

endmodule

// File: doc/imsic_access_arbiter.md
IMSIC_ACCESS_ARBITER -- requirements
Module: imsic_access_arbiter

Interface
REQ-001 SHALL have parameter NrHarts, default 2, number of requesting hart ports (>=2).
REQ-002 SHALL have parameter TimeoutCycles, default 255, watchdog limit in cycles; used only under IMSIC_ARB_TIMEOUT_EN.
REQ-003 SHALL have the following ports; one clock, reset synchronous and active-high.
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  NrHarts  per-hart access request
- req_ready_o  out  NrHarts  per-hart grant/accept
- req_we_i  in  NrHarts  1=write, 0=read
- req_claim_i  in  NrHarts  read-and-claim topei
- req_addr_i  in  NrHarts x 32  IMSIC register address
- req_wdata_i  in  NrHarts x 32  write data
- rsp_valid_o  out  NrHarts  one-cycle response strobe to granted hart
- rsp_rdata_o  out  32  response read data (shared)
- rsp_exception_o  out  1  response access fault (shared)
- imsic_valid_o  out  1  access to shared IMSIC register port
- imsic_hart_o  out  max(1,$clog2(NrHarts))  index of hart being served
- imsic_addr_o / imsic_data_o  out  32 / 32  latched address / write data
- imsic_we_o / imsic_claim_o  out  1 / 1  latched write / claim
- imsic_rvalid_i  in  1  IMSIC completion
- imsic_data_i  in  32  IMSIC read data, valid with imsic_rvalid_i
- imsic_exception_i  in  1  IMSIC fault, valid with imsic_rvalid_i

Function
REQ-004 SHALL implement FSM IDLE, BUSY, RESP; one access outstanding at a time.
REQ-005 IDLE: if any req_valid_i, SHALL pick winner round-robin starting at pointer, assert req_ready_o[winner] combinationally that cycle, latch we/claim/addr/wdata/index, go BUSY; else stay IDLE.
REQ-006 req_ready_o SHALL be one-hot or zero, asserted only in IDLE.
REQ-007 BUSY: imsic_valid_o=1 with latched fields held stable until imsic_rvalid_i; on imsic_rvalid_i SHALL latch imsic_data_i and imsic_exception_i, go RESP.
REQ-008 imsic_rvalid_i in the first BUSY cycle SHALL be accepted (minimum latency: grant t, response t+2).
REQ-009 RESP: rsp_valid_o[index]=1 for exactly one cycle with latched rdata/exception; pointer := (index+1) mod NrHarts; go IDLE; no grant in RESP.
REQ-010 For writes (we=1, claim=0) rsp_rdata_o SHALL be 0 regardless of imsic_data_i.
REQ-011 imsic_rvalid_i outside BUSY SHALL be ignored.
REQ-012 rsp_rdata_o/rsp_exception_o SHALL be 0 whenever no rsp_valid_o bit is set.
REQ-013 Requester deasserting req_valid_i while not granted SHALL simply lose eligibility; no state change.

Reset
REQ-014 On rst_i: state IDLE, pointer 0, all latches 0, all outputs 0 next cycle.
REQ-015 Reset mid-BUSY/RESP SHALL drop the access with no rsp_valid_o.

Configuration
REQ-016 IMSIC_ARB_TIMEOUT_EN defined: 8..16-bit counter clears on entering BUSY, increments each BUSY cycle without imsic_rvalid_i; reaching TimeoutCycles SHALL force RESP with rsp_exception_o=1, rsp_rdata_o=0.
REQ-017 IMSIC_ARB_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely.

Structure
REQ-018 Package imsic_arb_pkg SHALL hold the FSM state enum, ImsicAddrW=32, ImsicDataW=32.
REQ-019 Sub-module imsic_arb_rr SHALL compute the round-robin one-hot winner from request vector and pointer (combinational).

Verification
REQ-020 Reset, hart0 read addr 0x70, IMSIC rvalid 1 cycle later data 0x5 -> rsp_valid_o=01 at t+2, rdata 0x5, exc 0.
REQ-021 Both harts request continuously, immediate rvalid -> grants alternate 0,1,0,1; one access per 3 cycles.
REQ-022 Hart1 write addr 0x80 data 0xFF, imsic_data_i=0xAA -> imsic_we_o=1, imsic_data_o=0xFF, rsp rdata 0, exc 0.
REQ-023 imsic_exception_i=1 on claim read -> rsp_exception_o=1 to requester; pointer still advances.
REQ-024 rst_i asserted in BUSY -> no rsp_valid_o, imsic_valid_o=0 next cycle, next grant to hart0.
REQ-025 With IMSIC_ARB_TIMEOUT_EN, TimeoutCycles=4, no rvalid -> rsp_valid_o after 4 BUSY cycles, exc 1, rdata 0.
